generate_equations_walker: RTL and testbench

- Datapath responder for the equation-generation controller: answers its node-selection, node-status, element-type and next-element requests with done handshakes.
- Walks the node table and each node's linked list of circuit elements stored in external synchronous-read RAMs.
- Presents the current node and element to the stamping/compute datapath.

---
 rtl/generate_equations_walker_pkg.sv | 34 +++
 rtl/generate_equations_walker_if.sv | 57 +++++
 rtl/generate_equations_walker_go_edge_detect.sv | 32 +++
 rtl/generate_equations_walker.sv | 193 +++++++++++++++++++
 tb/tb_generate_equations_walker.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/generate_equations_walker_pkg.sv
// Shared types and record layout for the equation-generation walker.
package generate_equations_walker_pkg;

   localparam int NODE_W_DEF = 5;
   localparam int ELEM_W_DEF = 6;

   // Record flag fields sit directly above the pointer field: bit = ELEM_W + offset.
   localparam int NODE_NIL_OFS   = 0;
   localparam int NODE_VALID_OFS = 1;
   localparam int ELEM_NIL_OFS   = 0;
   localparam int ELEM_TYPE_OFS  = 1;

   localparam int REQ_RESET  = 0;
   localparam int REQ_CHOOSE = 1;
   localparam int REQ_STATUS = 2;
   localparam int REQ_TYPE   = 3;
   localparam int REQ_NEXT   = 4;
   localparam int REQ_N      = 5;

   typedef enum logic [1:0] {
      TYPE_NONE     = 2'b00,
      TYPE_VOLTAGE  = 2'b01,
      TYPE_CURRENT  = 2'b10,
      TYPE_RESISTOR = 2'b11
   } elem_type_e;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_NODE,
      WAIT_ELEM,
      RESP
   } state_e;

endpackage

// File: rtl/generate_equations_walker_if.sv
// Controller handshake plus node/element RAM ports of the walker.
interface generate_equations_walker_if
   import generate_equations_walker_pkg::*;
#(
   parameter int NODE_W = NODE_W_DEF,
   parameter int ELEM_W = ELEM_W_DEF
);
   logic              go_reset_data;
   logic              go_choose_node;
   logic              go_check_node_status;
   logic              go_check_element_type;
   logic              go_get_next_element;
   logic [NODE_W:0]   num_nodes;

   logic              node_rd_en;
   logic [NODE_W-1:0] node_addr;
   logic [ELEM_W+1:0] node_rd_data;
   logic              elem_rd_en;
   logic [ELEM_W-1:0] elem_addr;
   logic [ELEM_W+2:0] elem_rd_data;

   logic              data_reset_done;
   logic              node_chosen;
   logic              loop_done;
   logic              status_checked;
   logic              node_valid;
   logic              type_checked;
   logic              is_voltage;
   logic              is_current;
   logic              is_resistor;
   logic              next_element_got;
   logic              end_of_list;
   logic              elem_type_error;
   logic [NODE_W-1:0] cur_node;
   logic [ELEM_W-1:0] cur_elem;

   modport slave (
      input  go_reset_data, go_choose_node, go_check_node_status,
             go_check_element_type, go_get_next_element, num_nodes,
             node_rd_data, elem_rd_data,
      output node_rd_en, node_addr, elem_rd_en, elem_addr,
             data_reset_done, node_chosen, loop_done, status_checked,
             node_valid, type_checked, is_voltage, is_current, is_resistor,
             next_element_got, end_of_list, elem_type_error, cur_node, cur_elem
   );

   modport master (
      output go_reset_data, go_choose_node, go_check_node_status,
             go_check_element_type, go_get_next_element, num_nodes,
             node_rd_data, elem_rd_data,
      input  node_rd_en, node_addr, elem_rd_en, elem_addr,
             data_reset_done, node_chosen, loop_done, status_checked,
             node_valid, type_checked, is_voltage, is_current, is_resistor,
             next_element_got, end_of_list, elem_type_error, cur_node, cur_elem
   );

endinterface

// File: rtl/generate_equations_walker_go_edge_detect.sv
// Rising-edge detection of the five go_* requests, reduced to one prioritized request.
module go_edge_detect
   import generate_equations_walker_pkg::*;
(
   input  logic             clk,
   input  logic             program_reset,
   input  logic [REQ_N-1:0] go_i,
   output logic [REQ_N-1:0] req_o
);
   logic [REQ_N-1:0] go_q, go_d, rise;
   logic             found;

   // Lowest index has the highest priority; everything else rising with it is dropped.
   always_comb begin
      go_d  = go_i;
      rise  = go_i & ~go_q;
      req_o = '0;
      found = 1'b0;
      for (int i = 0; i < REQ_N; i++) begin
         if (rise[i] && !found) begin
            req_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (program_reset) go_q <= '0;
      else               go_q <= go_d;
   end

endmodule

// File: rtl/generate_equations_walker.sv
// Walks the node table and per-node element lists for the equation-generation controller.
module generate_equations_walker
   import generate_equations_walker_pkg::*;
#(
   parameter int NODE_W = NODE_W_DEF,
   parameter int ELEM_W = ELEM_W_DEF
) (
   input logic                        clk,
   input logic                        program_reset,
   generate_equations_walker_if.slave bus
);
   logic [REQ_N-1:0] go_vec, req;
   state_e           state_q, state_d;
   logic [NODE_W:0]  next_node_q, next_node_d, num_nodes_q, num_nodes_d;
   logic [NODE_W-1:0] cur_node_q, cur_node_d;
   logic [ELEM_W-1:0] cur_elem_q, cur_elem_d, next_ptr_q, next_ptr_d;
   logic next_nil_q, next_nil_d, elem_loaded_q, elem_loaded_d;
   logic data_reset_done_q, data_reset_done_d, loop_done_q, loop_done_d;
   logic node_valid_q, node_valid_d, elem_type_error_q, elem_type_error_d;
   logic is_voltage_q, is_voltage_d, is_current_q, is_current_d, is_resistor_q, is_resistor_d;
   logic node_chosen_q, node_chosen_d, status_checked_q, status_checked_d;
   logic type_checked_q, type_checked_d, next_element_got_q, next_element_got_d;
   logic end_of_list_q, end_of_list_d;
   logic idle;
   logic [1:0] elem_type;

   assign go_vec = {bus.go_get_next_element, bus.go_check_element_type,
                    bus.go_check_node_status, bus.go_choose_node, bus.go_reset_data};

   go_edge_detect u_edge (
      .clk           (clk),
      .program_reset (program_reset),
      .go_i          (go_vec),
      .req_o         (req)
   );

   assign idle      = (state_q == IDLE);
   assign elem_type = bus.elem_rd_data[ELEM_W+ELEM_TYPE_OFS +: 2];

   // Pulses default low so every pulse lasts only the single RESP cycle.
   always_comb begin
      state_d            = state_q;
      next_node_d        = next_node_q;
      num_nodes_d        = num_nodes_q;
      cur_node_d         = cur_node_q;
      cur_elem_d         = cur_elem_q;
      next_ptr_d         = next_ptr_q;
      next_nil_d         = next_nil_q;
      elem_loaded_d      = elem_loaded_q;
      data_reset_done_d  = data_reset_done_q & bus.go_reset_data;
      loop_done_d        = loop_done_q;
      node_valid_d       = node_valid_q;
      elem_type_error_d  = elem_type_error_q;
      is_voltage_d       = is_voltage_q;
      is_current_d       = is_current_q;
      is_resistor_d      = is_resistor_q;
      node_chosen_d      = 1'b0;
      status_checked_d   = 1'b0;
      type_checked_d     = 1'b0;
      next_element_got_d = 1'b0;
      end_of_list_d      = 1'b0;

      if (req[REQ_RESET]) begin
         state_d           = IDLE;
         next_node_d       = '0;
         num_nodes_d       = bus.num_nodes;
         cur_node_d        = '0;
         cur_elem_d        = '0;
         elem_loaded_d     = 1'b0;
         data_reset_done_d = 1'b1;
         loop_done_d       = 1'b0;
         node_valid_d      = 1'b0;
         elem_type_error_d = 1'b0;
         is_voltage_d      = 1'b0;
         is_current_d      = 1'b0;
         is_resistor_d     = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req[REQ_CHOOSE]) begin
                  if (next_node_q >= num_nodes_q) begin
                     loop_done_d = 1'b1;
                  end else begin
                     cur_node_d    = next_node_q[NODE_W-1:0];
                     next_node_d   = next_node_q + (NODE_W+1)'(1);
                     node_chosen_d = 1'b1;
                     state_d       = RESP;
                  end
               end else if (req[REQ_STATUS]) begin
                  elem_loaded_d = 1'b0;
                  state_d       = WAIT_NODE;
               end else if (req[REQ_TYPE]) begin
                  state_d = WAIT_ELEM;
               end else if (req[REQ_NEXT]) begin
                  if (!elem_loaded_q || next_nil_q) begin
                     end_of_list_d = 1'b1;
                  end else begin
                     cur_elem_d         = next_ptr_q;
                     next_element_got_d = 1'b1;
                  end
                  state_d = RESP;
               end
            end
            WAIT_NODE: begin
               node_valid_d     = bus.node_rd_data[ELEM_W+NODE_VALID_OFS] &
                                  ~bus.node_rd_data[ELEM_W+NODE_NIL_OFS];
               cur_elem_d       = bus.node_rd_data[ELEM_W-1:0];
               status_checked_d = 1'b1;
               state_d          = RESP;
            end
            WAIT_ELEM: begin
               next_ptr_d        = bus.elem_rd_data[ELEM_W-1:0];
               next_nil_d        = bus.elem_rd_data[ELEM_W+ELEM_NIL_OFS];
               elem_loaded_d     = 1'b1;
               is_voltage_d      = (elem_type == TYPE_VOLTAGE);
               is_current_d      = (elem_type == TYPE_CURRENT);
               is_resistor_d     = (elem_type == TYPE_RESISTOR);
               elem_type_error_d = elem_type_error_q | (elem_type == TYPE_NONE);
               type_checked_d    = 1'b1;
               state_d           = RESP;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (program_reset) begin
         state_q            <= IDLE;
         next_node_q        <= '0;
         num_nodes_q        <= '0;
         cur_node_q         <= '0;
         cur_elem_q         <= '0;
         next_ptr_q         <= '0;
         next_nil_q         <= 1'b0;
         elem_loaded_q      <= 1'b0;
         data_reset_done_q  <= 1'b0;
         loop_done_q        <= 1'b0;
         node_valid_q       <= 1'b0;
         elem_type_error_q  <= 1'b0;
         is_voltage_q       <= 1'b0;
         is_current_q       <= 1'b0;
         is_resistor_q      <= 1'b0;
         node_chosen_q      <= 1'b0;
         status_checked_q   <= 1'b0;
         type_checked_q     <= 1'b0;
         next_element_got_q <= 1'b0;
         end_of_list_q      <= 1'b0;
      end else begin
         state_q            <= state_d;
         next_node_q        <= next_node_d;
         num_nodes_q        <= num_nodes_d;
         cur_node_q         <= cur_node_d;
         cur_elem_q         <= cur_elem_d;
         next_ptr_q         <= next_ptr_d;
         next_nil_q         <= next_nil_d;
         elem_loaded_q      <= elem_loaded_d;
         data_reset_done_q  <= data_reset_done_d;
         loop_done_q        <= loop_done_d;
         node_valid_q       <= node_valid_d;
         elem_type_error_q  <= elem_type_error_d;
         is_voltage_q       <= is_voltage_d;
         is_current_q       <= is_current_d;
         is_resistor_q      <= is_resistor_d;
         node_chosen_q      <= node_chosen_d;
         status_checked_q   <= status_checked_d;
         type_checked_q     <= type_checked_d;
         next_element_got_q <= next_element_got_d;
         end_of_list_q      <= end_of_list_d;
      end
   end

   // Addresses come straight from cur_node/cur_elem, which cannot change while a read is pending.
   assign bus.node_rd_en       = ~program_reset & idle & req[REQ_STATUS];
   assign bus.node_addr        = cur_node_q;
   assign bus.elem_rd_en       = ~program_reset & idle & req[REQ_TYPE];
   assign bus.elem_addr        = cur_elem_q;
   assign bus.data_reset_done  = data_reset_done_q;
   assign bus.node_chosen      = node_chosen_q;
   assign bus.loop_done        = loop_done_q;
   assign bus.status_checked   = status_checked_q;
   assign bus.node_valid       = node_valid_q;
   assign bus.type_checked     = type_checked_q;
   assign bus.is_voltage       = is_voltage_q;
   assign bus.is_current       = is_current_q;
   assign bus.is_resistor      = is_resistor_q;
   assign bus.next_element_got = next_element_got_q;
   assign bus.end_of_list      = end_of_list_q;
   assign bus.elem_type_error  = elem_type_error_q;
   assign bus.cur_node         = cur_node_q;
   assign bus.cur_elem         = cur_elem_q;

endmodule

// File: tb/tb_generate_equations_walker.sv
// Directed per-cycle vector table for the walker, plus a full 2^NODE_W choose sweep.
module tb_generate_equations_walker;
   import generate_equations_walker_pkg::*;

   logic clk = 1'b0;
   logic program_reset;
   always #5 clk = ~clk;

   generate_equations_walker_if bus ();

   generate_equations_walker dut (
      .clk           (clk),
      .program_reset (program_reset),
      .bus           (bus)
   );

   logic [7:0] node_mem [0:31];
   logic [8:0] elem_mem [0:63];

   always @(posedge clk) begin
      if (bus.node_rd_en) bus.node_rd_data <= node_mem[bus.node_addr];
      if (bus.elem_rd_en) bus.elem_rd_data <= elem_mem[bus.elem_addr];
   end

   localparam logic [13:0] F_NONE = 14'h0000;
   localparam logic [13:0] F_DRD  = 14'h2000;
   localparam logic [13:0] F_CH   = 14'h1000;
   localparam logic [13:0] F_LD   = 14'h0800;
   localparam logic [13:0] F_SC   = 14'h0400;
   localparam logic [13:0] F_NV   = 14'h0200;
   localparam logic [13:0] F_TC   = 14'h0100;
   localparam logic [13:0] F_ISV  = 14'h0080;
   localparam logic [13:0] F_ISC  = 14'h0040;
   localparam logic [13:0] F_ISR  = 14'h0020;
   localparam logic [13:0] F_NG   = 14'h0010;
   localparam logic [13:0] F_EOL  = 14'h0008;
   localparam logic [13:0] F_ERR  = 14'h0004;
   localparam logic [13:0] F_NRD  = 14'h0002;
   localparam logic [13:0] F_ERD  = 14'h0001;

   localparam logic [4:0] G_NONE = 5'd0;
   localparam logic [4:0] G_RST  = 5'd1;
   localparam logic [4:0] G_CH   = 5'd2;
   localparam logic [4:0] G_ST   = 5'd4;
   localparam logic [4:0] G_TY   = 5'd8;
   localparam logic [4:0] G_NX   = 5'd16;

   typedef struct {
      logic        prst;
      logic [4:0]  go;
      logic [5:0]  nn;
      logic [13:0] flags;
      logic [4:0]  node;
      logic [5:0]  elem;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   failures = 0;
   int   chosen_cnt;
   int   wide_done;
   logic [4:0] last_node;

   task automatic addVec(input logic prst, input logic [4:0] go, input logic [5:0] nn,
                         input logic [13:0] flags, input logic [4:0] node, input logic [5:0] elem);
      vec_t v;
      v.prst = prst; v.go = go; v.nn = nn; v.flags = flags; v.node = node; v.elem = elem;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input logic prst, input logic [4:0] go, input logic [5:0] nn);
      program_reset             = prst;
      bus.go_reset_data         = go[0];
      bus.go_choose_node        = go[1];
      bus.go_check_node_status  = go[2];
      bus.go_check_element_type = go[3];
      bus.go_get_next_element   = go[4];
      bus.num_nodes             = nn;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
      end
   endtask

   function automatic logic [31:0] snapshot();
      logic [13:0] f;
      f = {bus.data_reset_done, bus.node_chosen, bus.loop_done, bus.status_checked,
           bus.node_valid, bus.type_checked, bus.is_voltage, bus.is_current,
           bus.is_resistor, bus.next_element_got, bus.end_of_list, bus.elem_type_error,
           bus.node_rd_en, bus.elem_rd_en};
      return {7'd0, f, bus.cur_node, bus.cur_elem};
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) node_mem[i] = 8'h00;
      for (int i = 0; i < 64; i++) elem_mem[i] = 9'h000;
      node_mem[1]  = 8'b1_0_000101;
      node_mem[2]  = 8'b1_0_001100;
      elem_mem[0]  = 9'b10_1_000000;
      elem_mem[5]  = 9'b11_0_001001;
      elem_mem[9]  = 9'b01_1_000000;
      elem_mem[12] = 9'b00_1_000000;

      // Each row: inputs driven this cycle, outputs expected mid-cycle.
      addVec(1'b1, G_NONE, 6'd3, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_RST,  6'd3, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_RST,  6'd3, F_DRD,  5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_DRD,  5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_CH,   6'd3, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_CH,   5'd0, 6'd0);
      addVec(1'b0, G_ST,   6'd3, F_NRD,  5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_SC,   5'd0, 6'd0);
      addVec(1'b0, G_CH,   6'd3, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_CH,   5'd1, 6'd0);
      addVec(1'b0, G_ST,   6'd3, F_NRD,  5'd1, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_NONE, 5'd1, 6'd0);
      addVec(1'b0, G_NONE, 6'd3, F_SC | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_TY,   6'd3, F_ERD | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_NONE, 6'd3, F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_NONE, 6'd3, F_TC | F_ISR | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_NX,   6'd3, F_ISR | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_NONE, 6'd3, F_NG | F_ISR | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_TY,   6'd3, F_ERD | F_ISR | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_NONE, 6'd3, F_ISR | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_NONE, 6'd3, F_TC | F_ISV | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_NX,   6'd3, F_ISV | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_NONE, 6'd3, F_EOL | F_ISV | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_ST,   6'd3, F_NRD | F_ISV | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_TY,   6'd3, F_ISV | F_NV, 5'd1, 6'd9);
      addVec(1'b0, G_NONE, 6'd3, F_SC | F_ISV | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_NX,   6'd3, F_ISV | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_NONE, 6'd3, F_EOL | F_ISV | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_CH | G_ST, 6'd3, F_ISV | F_NV, 5'd1, 6'd5);
      addVec(1'b0, G_NONE, 6'd3, F_CH | F_ISV | F_NV, 5'd2, 6'd5);
      addVec(1'b0, G_ST,   6'd3, F_NRD | F_ISV | F_NV, 5'd2, 6'd5);
      addVec(1'b0, G_NONE, 6'd3, F_ISV | F_NV, 5'd2, 6'd5);
      addVec(1'b0, G_NONE, 6'd3, F_SC | F_ISV | F_NV, 5'd2, 6'd12);
      addVec(1'b0, G_TY,   6'd3, F_ERD | F_ISV | F_NV, 5'd2, 6'd12);
      addVec(1'b0, G_NONE, 6'd3, F_ISV | F_NV, 5'd2, 6'd12);
      addVec(1'b0, G_NONE, 6'd3, F_TC | F_NV | F_ERR, 5'd2, 6'd12);
      addVec(1'b0, G_NONE, 6'd3, F_NV | F_ERR, 5'd2, 6'd12);
      addVec(1'b0, G_CH,   6'd3, F_NV | F_ERR, 5'd2, 6'd12);
      addVec(1'b0, G_NONE, 6'd3, F_LD | F_NV | F_ERR, 5'd2, 6'd12);
      addVec(1'b0, G_NONE, 6'd3, F_LD | F_NV | F_ERR, 5'd2, 6'd12);
      addVec(1'b0, G_RST,  6'd0, F_LD | F_NV | F_ERR, 5'd2, 6'd12);
      addVec(1'b0, G_NONE, 6'd0, F_DRD, 5'd0, 6'd0);
      addVec(1'b0, G_CH,   6'd0, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_LD, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_LD, 5'd0, 6'd0);
      addVec(1'b0, G_ST,   6'd0, F_LD | F_NRD, 5'd0, 6'd0);
      addVec(1'b0, G_RST,  6'd0, F_LD, 5'd0, 6'd0);
      addVec(1'b0, G_RST,  6'd0, F_DRD, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_DRD, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_TY,   6'd0, F_ERD, 5'd0, 6'd0);
      addVec(1'b1, G_NONE, 6'd0, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_TY,   6'd0, F_ERD, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_NONE, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_TC | F_ISC, 5'd0, 6'd0);
      addVec(1'b0, G_NX,   6'd0, F_ISC, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_EOL | F_ISC, 5'd0, 6'd0);
      addVec(1'b0, G_NX,   6'd0, F_ISC, 5'd0, 6'd0);
      addVec(1'b0, G_NX,   6'd0, F_EOL | F_ISC, 5'd0, 6'd0);
      addVec(1'b0, G_NX,   6'd0, F_ISC, 5'd0, 6'd0);
      addVec(1'b0, G_NONE, 6'd0, F_ISC, 5'd0, 6'd0);

      applyStimulus(1'b1, G_NONE, 6'd0);
      repeat (2) @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].prst, vecs[i].go, vecs[i].nn);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), snapshot(),
                     {7'd0, vecs[i].flags, vecs[i].node, vecs[i].elem});
         @(posedge clk);
         #1;
      end

      // With num_nodes = 2^NODE_W every index must be chosen once before loop_done.
      applyStimulus(1'b0, G_RST, 6'd32);
      @(posedge clk); #1;
      applyStimulus(1'b0, G_NONE, 6'd32);
      @(posedge clk); #1;
      chosen_cnt = 0;
      wide_done  = 0;
      last_node  = '0;
      for (int k = 0; k < 40 && wide_done == 0; k++) begin
         applyStimulus(1'b0, G_CH, 6'd32);
         @(posedge clk); #1;
         applyStimulus(1'b0, G_NONE, 6'd32);
         @(negedge clk);
         if (bus.node_chosen) begin
            chosen_cnt++;
            last_node = bus.cur_node;
         end
         if (bus.loop_done) wide_done = 1;
         @(posedge clk); #1;
      end
      checkOutput("wide_chosen_count", chosen_cnt, 32'd32);
      checkOutput("wide_last_node", 32'(last_node), 32'd31);
      checkOutput("wide_loop_done", wide_done, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
